// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Accepts a one-cycle uart_send while uart_ready is high; tx_done pulses once per completed frame.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_send,
   input  logic [7:0] uart_data,
   output logic       uart_ready,
   output logic       tx,
   output logic       tx_done
);

   localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
   localparam logic              STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic              HAS_PARITY = (PARITY != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic              parity_bit;
   logic              stop_cnt;
   logic              bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);

   // Even parity makes the total count of ones even; odd parity is its inverse.
   function automatic logic calc_parity(input logic [7:0] d);
      if (PARITY == 2) begin
         return ~(^d);
      end else begin
         return ^d;
      end
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         uart_ready <= 1'b1;
         tx_done    <= 1'b0;
         baud_cnt   <= '0;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         parity_bit <= 1'b0;
         stop_cnt   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx         <= 1'b1;
               uart_ready <= 1'b1;
               baud_cnt   <= '0;
               bit_cnt    <= 3'd0;
               stop_cnt   <= 1'b0;
               if (uart_send) begin
                  shift      <= uart_data;
                  parity_bit <= calc_parity(uart_data);
                  tx         <= 1'b0;
                  uart_ready <= 1'b0;
                  state      <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= shift[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= 3'd0;
                     if (HAS_PARITY) begin
                        tx    <= parity_bit;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     // shift[1] is the bit that lands in the LSB after this shift
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (stop_cnt == STOP_LAST) begin
                     stop_cnt   <= 1'b0;
                     state      <= S_IDLE;
                     uart_ready <= 1'b1;
                     tx_done    <= 1'b1;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            default: begin
               state      <= S_IDLE;
               tx         <= 1'b1;
               uart_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameterisations checked cycle by cycle against frames
// built from the bit-level frame definition, plus a sampling UART receiver on instance 0.
module tb_uart_tx_serializer;

   localparam int CPB0 = 4, PAR0 = 0, STP0 = 1;
   localparam int CPB1 = 4, PAR1 = 1, STP1 = 2;
   localparam int CPB2 = 3, PAR2 = 2, STP2 = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] send = 3'b000;
   logic [7:0] data_v [3];
   logic [2:0] tx_v;
   logic [2:0] rdy_v;
   logic [2:0] done_v;

   int checks = 0;
   int errors = 0;
   logic rx_en = 1'b0;
   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB0), .PARITY(PAR0), .STOP_BITS(STP0)) dut0 (
      .clk(clk), .reset(reset), .uart_send(send[0]), .uart_data(data_v[0]),
      .uart_ready(rdy_v[0]), .tx(tx_v[0]), .tx_done(done_v[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB1), .PARITY(PAR1), .STOP_BITS(STP1)) dut1 (
      .clk(clk), .reset(reset), .uart_send(send[1]), .uart_data(data_v[1]),
      .uart_ready(rdy_v[1]), .tx(tx_v[1]), .tx_done(done_v[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB2), .PARITY(PAR2), .STOP_BITS(STP2)) dut2 (
      .clk(clk), .reset(reset), .uart_send(send[2]), .uart_data(data_v[2]),
      .uart_ready(rdy_v[2]), .tx(tx_v[2]), .tx_done(done_v[2]));

   function automatic int cpb_of(input int s);
      case (s)
         0:       return CPB0;
         1:       return CPB1;
         default: return CPB2;
      endcase
   endfunction

   function automatic int par_of(input int s);
      case (s)
         0:       return PAR0;
         1:       return PAR1;
         default: return PAR2;
      endcase
   endfunction

   function automatic int stop_of(input int s);
      case (s)
         0:       return STP0;
         1:       return STP1;
         default: return STP2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_idle(input string tag);
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("%s tx s%0d", tag, s), tx_v[s], 1'b1);
         chk($sformatf("%s ready s%0d", tag, s), rdy_v[s], 1'b1);
         chk($sformatf("%s done s%0d", tag, s), done_v[s], 1'b0);
      end
   endtask

   // Called at a negedge with the instance idle. Sends d, then checks every cycle of the frame
   // plus the completion cycle. busy_at>0 injects an ignored send; abort_at>0 resets mid-frame.
   task automatic run_frame(input int sel, input logic [7:0] d, input int busy_at,
                            input logic [7:0] busy_d, input int abort_at);
      int   cpb, par, ns, f;
      logic slot [12];
      logic et, er, ed;
      cpb = cpb_of(sel);
      par = par_of(sel);
      slot[0] = 1'b0;
      for (int i = 0; i < 8; i++) slot[1+i] = d[i];
      ns = 9;
      if (par == 1) begin
         slot[ns] = ($countones(d) % 2 == 1);
         ns++;
      end else if (par == 2) begin
         slot[ns] = ($countones(d) % 2 == 0);
         ns++;
      end
      for (int i = 0; i < stop_of(sel); i++) begin
         slot[ns] = 1'b1;
         ns++;
      end
      f = ns * cpb;
      chk($sformatf("pre ready s%0d", sel), rdy_v[sel], 1'b1);
      send[sel]   = 1'b1;
      data_v[sel] = d;
      for (int k = 1; k <= f + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            send[sel]   = 1'b0;
            data_v[sel] = 8'($urandom);
         end
         if (abort_at > 0 && k > abort_at) begin
            et = 1'b1; er = 1'b1; ed = 1'b0;
         end else if (k <= f) begin
            et = slot[(k-1)/cpb]; er = 1'b0; ed = 1'b0;
         end else begin
            et = 1'b1; er = 1'b1; ed = 1'b1;
         end
         chk($sformatf("tx s%0d d%02h k%0d", sel, d, k), tx_v[sel], et);
         chk($sformatf("ready s%0d d%02h k%0d", sel, d, k), rdy_v[sel], er);
         chk($sformatf("done s%0d d%02h k%0d", sel, d, k), done_v[sel], ed);
         if (k == busy_at) begin
            send[sel]   = 1'b1;
            data_v[sel] = busy_d;
         end else if (k == busy_at + 1) begin
            send[sel] = 1'b0;
         end
         if (k == abort_at) reset = 1'b1;
         else if (k == abort_at + 1) reset = 1'b0;
      end
   endtask

   // Bench receiver: finds the start edge, samples mid-bit, checks the stop bit.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && tx_v[0] === 1'b0) begin
            repeat (CPB0 / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB0) @(negedge clk);
               b[i] = tx_v[0];
            end
            repeat (CPB0) @(negedge clk);
            chk("rx stop", tx_v[0], 1'b1);
            rx_q.push_back(b);
         end
      end
   end

   initial begin
      logic [7:0] txt [6];
      logic [7:0] r;
      txt[0] = 8'h33; txt[1] = 8'h30; txt[2] = 8'h30;
      txt[3] = 8'h30; txt[4] = 8'h0D; txt[5] = 8'h0A;
      for (int s = 0; s < 3; s++) data_v[s] = 8'h00;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_idle($sformatf("reset c%0d", c));
      end
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk_idle($sformatf("post reset c%0d", c));
      end

      run_frame(0, 8'h41, 10, 8'h7E, 0);
      run_frame(1, 8'h07, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         r = 8'($urandom);
         run_frame(1, r, $urandom_range(2, 40), 8'($urandom), 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         r = 8'($urandom);
         run_frame(2, r, $urandom_range(2, 25), 8'($urandom), 0);
      end

      rx_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(txt[i]);
         run_frame(0, txt[i], 0, 8'h00, 0);
      end
      for (int i = 0; i < 6; i++) begin
         r = 8'($urandom);
         exp_q.push_back(r);
         run_frame(0, r, 0, 8'h00, 0);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      rx_en = 1'b0;
      chk_int("rx count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) chk_int($sformatf("rx byte %0d", i), int'(rx_q[i]), int'(exp_q[i]));
      end

      run_frame(0, 8'hA5, 0, 8'h00, 18);
      run_frame(0, 8'h5A, 0, 8'h00, 0);
      repeat (2) @(negedge clk);
      chk_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
